// File: rtl/cmd_fifo_reader.sv
// Read-side consumer for the command async FIFO: hides the FIFO's registered
// read latency behind a small ring buffer and presents a valid/ready command stream.
module cmd_fifo_reader #(
  parameter int WIDTH     = 72,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  input  logic                 fifo_empty,
  input  logic                 flush,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_is_read,
  output logic [6:0]           cmd_addr,
  output logic [63:0]          cmd_data,
  output logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 idle
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    buf_count;
  logic [CW:0]      occ;
  logic             inflight, pop;
  logic [WIDTH-1:0] head_entry;

  assign pop = cmd_valid && cmd_ready;
  // Buffered plus in-flight words; a pop this cycle frees the slot the new read needs.
  assign occ = {1'b0, buf_count} + (CW+1)'(inflight);
  assign fifo_rd_en = !rst && !flush && !fifo_empty &&
                      ((occ < DEPTH) || ((occ == DEPTH) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
      inflight  <= 1'b0;
      cmd_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) cmd_count <= cmd_count + CNT_WIDTH'(1);
      if (flush) begin
        // Returning word (if any) is dropped by simply not capturing it.
        buf_count <= '0;
        head      <= tail;
      end else begin
        if (inflight) begin
          buf_q[tail] <= fifo_rd_data;
          tail        <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        buf_count <= buf_count + CW'(inflight) - CW'(pop);
      end
    end
  end

  assign head_entry  = buf_q[head];
  assign cmd_valid   = (buf_count != '0);
  assign cmd_is_read = head_entry[WIDTH-1];
  assign cmd_addr    = head_entry[WIDTH-2 -: 7];
  assign cmd_data    = head_entry[63:0];
  assign idle        = (buf_count == '0) && !inflight && fifo_empty;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    {1'b0, buf_count} <= DEPTH);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(inflight && !pop && ({1'b0, buf_count} == DEPTH)));
  a_no_empty_read: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));
endmodule

// File: tb/tb_cmd_fifo_reader.sv
// Bench for cmd_fifo_reader: queue-based FIFO model, accepted-command monitor and
// per-scenario tasks comparing against the expected command stream.
module tb_cmd_fifo_reader;
  localparam int W  = 72;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst, flush, cmd_ready;
  logic        fifo_empty, fifo_rd_en, cmd_valid, cmd_is_read, idle;
  logic [W-1:0] fifo_rd_data = '0;
  logic [6:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic [15:0] cmd_count;

  int n_chk = 0, n_pass = 0;
  logic [15:0] exp_cnt = '0;

  cmd_fifo_reader #(.WIDTH(72), .BUF_DEPTH(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_read(cmd_is_read), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .idle(idle));

  always #5 clk = ~clk;

  // FIFO model: registered read data, one cycle after the pop request
  logic [W-1:0] fmem [FD];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr % FD];
      rd_ptr       <= rd_ptr + 1;
    end

  // every accepted command, in acceptance order
  logic [W-1:0] got [$];
  always @(negedge clk)
    if (!rst && cmd_valid && cmd_ready) got.push_back({cmd_is_read, cmd_addr, cmd_data});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] e);
    fmem[wr_ptr % FD] = e;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_got(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (got.size() >= target) begin ok = 1'b1; break; end
      tick();
    end
    if (got.size() >= target) ok = 1'b1;
  endtask

  function automatic logic [W-1:0] mk(input int a, input logic [63:0] d, input logic rd);
    return {rd, 7'(a), d};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en c%0d: got %b exp 0", c, fifo_rd_en); else n_pass++;
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid c%0d: got %b exp 0", c, cmd_valid); else n_pass++;
      n_chk++; if (idle !== 1'b1) $display("FAIL reset_idle c%0d: got %b exp 1", c, idle); else n_pass++;
      n_chk++; if (cmd_count !== 16'h0) $display("FAIL reset_count c%0d: got %h exp 0", c, cmd_count); else n_pass++;
    end
    n_chk++;
    if ({cmd_is_read, cmd_addr, cmd_data} !== 72'h0)
      $display("FAIL reset_data: got %h exp 0", {cmd_is_read, cmd_addr, cmd_data});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    e = 72'h80_0000_0000_DEAD_BEEF;
    tick(); cmd_ready = 1'b1; push(e);
    @(negedge clk);  // cycle N
    n_chk++; if (fifo_rd_en !== 1'b1) $display("FAIL single_rd_en_N: got %b exp 1", fifo_rd_en); else n_pass++;
    @(negedge clk);  // N+1
    n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL single_rd_en_N1: got %b exp 0", fifo_rd_en); else n_pass++;
    n_chk++; if (cmd_valid !== 1'b0) $display("FAIL single_valid_N1: got %b exp 0", cmd_valid); else n_pass++;
    @(negedge clk);  // N+2
    n_chk++; if (cmd_valid !== 1'b1) $display("FAIL single_valid_N2: got %b exp 1", cmd_valid); else n_pass++;
    n_chk++; if (cmd_is_read !== 1'b1) $display("FAIL single_is_read: got %b exp 1", cmd_is_read); else n_pass++;
    n_chk++; if (cmd_addr !== 7'h00) $display("FAIL single_addr: got %h exp 00", cmd_addr); else n_pass++;
    n_chk++; if (cmd_data !== 64'h0000_0000_DEAD_BEEF) $display("FAIL single_data: got %h exp deadbeef", cmd_data); else n_pass++;
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);  // N+3
    n_chk++; if (cmd_valid !== 1'b0) $display("FAIL single_valid_N3: got %b exp 0", cmd_valid); else n_pass++;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL single_count: got %0d exp %0d", cmd_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ref_q [$];
    bit v [40];
    int base, first, run;
    bit ok;
    base = got.size();
    tick(); cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_q.push_back(mk(i, 64'(i), 1'($urandom)));
      push(ref_q[i]);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); v[c] = cmd_valid;
    end
    first = -1; run = 0;
    for (int c = 0; c < 40; c++) begin
      if (v[c] && first < 0) first = c;
      if (first >= 0 && c >= first && c < first + 17 && v[c] && run == c - first) run++;
    end
    n_chk++; if (first !== 2) $display("FAIL b2b_first_valid: got cycle %0d exp 2", first); else n_pass++;
    n_chk++; if (run !== 16) $display("FAIL b2b_run_len: got %0d exp 16", run); else n_pass++;
    wait_got(base + 16, 20, ok);
    n_chk++; if (!ok) $display("FAIL b2b_timeout: got %0d exp %0d", got.size() - base, 16); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (base + i >= got.size() || got[base+i] !== ref_q[i])
        $display("FAIL b2b_order[%0d]: got %h exp %h", i, (base + i < got.size()) ? got[base+i] : 'x, ref_q[i]);
      else n_pass++;
    end
    exp_cnt = exp_cnt + 16'd16;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL b2b_count: got %0d exp %0d", cmd_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ref_q [$];
    logic [W-1:0] held;
    int base;
    bit ok;
    base = got.size();
    held = '0;
    tick();
    for (int i = 0; i < 16; i++) begin
      ref_q.push_back(mk(i, 64'(i), 1'($urandom)));
      push(ref_q[i]);
    end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      cmd_ready = !(c >= 7 && c <= 11);
      @(negedge clk);
      if (c == 7) held = {cmd_is_read, cmd_addr, cmd_data};
      if (c >= 7 && c <= 11) begin
        n_chk++; if (cmd_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b exp 1", c, cmd_valid); else n_pass++;
        n_chk++;
        if ({cmd_is_read, cmd_addr, cmd_data} !== held)
          $display("FAIL bp_head_stable c%0d: got %h exp %h", c, {cmd_is_read, cmd_addr, cmd_data}, held);
        else n_pass++;
      end
      if (c >= 8 && c <= 11) begin
        n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en c%0d: got %b exp 0", c, fifo_rd_en); else n_pass++;
      end
    end
    wait_got(base + 16, 20, ok);
    n_chk++; if (!ok || got.size() != base + 16) $display("FAIL bp_total: got %0d exp 16", got.size() - base); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (base + i >= got.size() || got[base+i] !== ref_q[i])
        $display("FAIL bp_order[%0d]: got %h exp %h", i, (base + i < got.size()) ? got[base+i] : 'x, ref_q[i]);
      else n_pass++;
    end
    exp_cnt = exp_cnt + 16'd16;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL bp_count: got %0d exp %0d", cmd_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    logic [W-1:0] e [4];
    int base;
    bit ok;
    base = got.size();
    for (int i = 0; i < 4; i++) e[i] = mk(32 + i, {$urandom, $urandom}, 1'($urandom));
    tick(); cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(e[i]);
    repeat (3) tick();
    cmd_ready = 1'b1;  // pop first entry; third entry gets requested
    @(negedge clk);
    n_chk++; if (fifo_rd_en !== 1'b1) $display("FAIL flush_pre_rd_en: got %b exp 1", fifo_rd_en); else n_pass++;
    tick(); flush = 1'b1;  // second entry still popped in this cycle
    @(negedge clk);
    n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL flush_rd_en_forced: got %b exp 0", fifo_rd_en); else n_pass++;
    n_chk++; if (cmd_valid !== 1'b1) $display("FAIL flush_cycle_valid: got %b exp 1", cmd_valid); else n_pass++;
    tick(); flush = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_valid !== 1'b0) $display("FAIL flush_after_valid: got %b exp 0", cmd_valid); else n_pass++;
    wait_got(base + 3, 20, ok);
    n_chk++; if (!ok) $display("FAIL flush_timeout: got %0d exp 3", got.size() - base); else n_pass++;
    repeat (3) tick();
    n_chk++; if (got.size() != base + 3) $display("FAIL flush_total: got %0d exp 3", got.size() - base); else n_pass++;
    n_chk++; if (got.size() < base + 3 || got[base] !== e[0]) $display("FAIL flush_item0: got %h exp %h", got[base], e[0]); else n_pass++;
    n_chk++; if (got.size() < base + 3 || got[base+1] !== e[1]) $display("FAIL flush_item1: got %h exp %h", got[base+1], e[1]); else n_pass++;
    n_chk++; if (got.size() < base + 3 || got[base+2] !== e[3]) $display("FAIL flush_item2: got %h exp %h", got[base+2], e[3]); else n_pass++;
    exp_cnt = exp_cnt + 16'd3;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL flush_count: got %0d exp %0d", cmd_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] ref_q [$];
    int base, pushed, c, bad;
    base = got.size(); pushed = 0; c = 0; bad = 0;
    for (int i = 0; i < 40; i++) ref_q.push_back(mk($urandom_range(0, 127), {$urandom, $urandom}, 1'($urandom)));
    while (got.size() < base + 40 && c < 2000) begin
      tick(); c++;
      cmd_ready = ($urandom % 3) != 0;
      if (pushed < 40 && (wr_ptr - rd_ptr) < FD && ($urandom % 2) == 1) begin
        push(ref_q[pushed]); pushed++;
      end
    end
    cmd_ready = 1'b0;
    tick();
    n_chk++; if (got.size() != base + 40) $display("FAIL rand_total: got %0d exp 40", got.size() - base); else n_pass++;
    for (int i = 0; i < 40; i++)
      if (base + i >= got.size() || got[base+i] !== ref_q[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL rand_order: got %0d wrong entries exp 0", bad); else n_pass++;
    exp_cnt = exp_cnt + 16'd40;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL rand_count: got %0d exp %0d", cmd_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(); cmd_ready = 1'b0;
    push(mk(5, 64'h1111, 1'b1));
    push(mk(6, 64'h2222, 1'b1));
    tick(); tick();
    rst = 1'b1;  // first word buffered, second in flight
    @(negedge clk);
    n_chk++; if (cmd_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b exp 1", cmd_valid); else n_pass++;
    tick(); rst = 1'b0; cmd_ready = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    n_chk++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_valid: got %b exp 0", cmd_valid); else n_pass++;
    n_chk++;
    if ({cmd_is_read, cmd_addr, cmd_data} !== 72'h0)
      $display("FAIL rstmid_data: got %h exp 0", {cmd_is_read, cmd_addr, cmd_data});
    else n_pass++;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL rstmid_count: got %0d exp 0", cmd_count); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL rstmid_idle: got %b exp 1", idle); else n_pass++;
    n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b exp 0", fifo_rd_en); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_abandon c%0d: got %b exp 0", c, cmd_valid); else n_pass++;
    end
  endtask

  task automatic stream(input int n, input int budget);
    int base, pushed, c;
    base = got.size(); pushed = 0; c = 0;
    cmd_ready = 1'b1;
    while (got.size() < base + n && c < budget) begin
      tick(); c++;
      if (pushed < n && (wr_ptr - rd_ptr) < FD) begin
        push(mk(pushed % 128, 64'(pushed), pushed[0])); pushed++;
      end
    end
    tick();
  endtask

  task automatic test_count_wrap();
    int base;
    base = got.size();
    stream(65536, 65700);
    exp_cnt = exp_cnt + 16'hFFFF + 16'd1;
    n_chk++; if (got.size() != base + 65536) $display("FAIL wrap_total: got %0d exp 65536", got.size() - base); else n_pass++;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL wrap_to_zero: got %h exp %h", cmd_count, exp_cnt); else n_pass++;
    stream(1, 50);
    exp_cnt = exp_cnt + 16'd1;
    n_chk++; if (cmd_count !== exp_cnt) $display("FAIL wrap_to_one: got %h exp %h", cmd_count, exp_cnt); else n_pass++;
    n_chk++;
    if (got.size() != base + 65537 || got[got.size()-1] !== mk(0, 64'h0, 1'b0))
      $display("FAIL wrap_last_item: got %h exp %h", got[got.size()-1], mk(0, 64'h0, 1'b0));
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cmd_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cmd_fifo_reader.md
Name: cmd_fifo_reader

Overview:
- Read-side consumer for the command async FIFO. Runs entirely in the GPU core clock domain and drives the FIFO read port (rd_en, rd_data, rd_empty).
- Absorbs the FIFO's 1-cycle registered read latency. Prefetches into a small local buffer.
- Presents decoded register commands to the register file / command dispatcher as a valid/ready stream at up to 1 command per cycle.
- Supports a synchronous flush that discards buffered and in-flight commands.

Parameters:
- WIDTH, 72, FIFO entry width; bit 71 = read flag, bits 70:64 = register address, bits 63:0 = data.
- BUF_DEPTH, 2, local prefetch buffer entries; power of 2, minimum 2.
- CNT_WIDTH, 16, width of the accepted-command counter.

Ports:
- clk  in  1  core clock (same clock as the FIFO rd_clk).
- rst  in  1  reset, synchronous, active-high.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_rd_data  in  WIDTH  FIFO registered read data; valid the cycle after fifo_rd_en && !fifo_empty.
- fifo_empty  in  1  FIFO empty flag.
- flush  in  1  discard all buffered/in-flight entries (single-cycle pulse or level).
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts.
- cmd_is_read  out  1  bit 71 of head entry.
- cmd_addr  out  7  bits 70:64 of head entry.
- cmd_data  out  64  bits 63:0 of head entry.
- cmd_count  out  CNT_WIDTH  number of commands accepted (valid && ready); wraps.
- idle  out  1  buffer empty, nothing in flight, fifo_empty high.

Behaviour:
- Reset (rst high at a clk edge):
  - buf_count = 0, inflight = 0, buffer pointers = 0, cmd_count = 0.
  - fifo_rd_en = 0, cmd_valid = 0, cmd_* data = 0, idle = 1.
  - Reset mid-transfer abandons any in-flight word; the returning data is ignored.
- Pop condition (combinational):
  - pop = cmd_valid && cmd_ready.
  - fifo_rd_en = !rst && !flush && !fifo_empty && ((buf_count + inflight) < BUF_DEPTH, or == BUF_DEPTH with pop this cycle).
  - fifo_rd_en is never asserted while fifo_empty is high.
- inflight is a 1-bit register = fifo_rd_en of the previous cycle.
  - When inflight = 1, fifo_rd_data is written into the buffer at the tail at that cycle's edge.
- Buffer is a circular BUF_DEPTH register array with wrapping head/tail pointers.
  - buf_count updates by +inflight −pop; simultaneous capture and pop leaves the count unchanged.
  - buf_count never exceeds BUF_DEPTH. Exceeding it is a design error; cover it with an assertion.
- Outputs:
  - cmd_valid = (buf_count != 0).
  - cmd_is_read, cmd_addr and cmd_data are decoded from the head entry.
  - The head is stable while cmd_valid && !cmd_ready.
- Latency: with the buffer empty, fifo_empty falling in cycle N gives fifo_rd_en in N, capture at end of N+1, and cmd_valid in N+2.
- Throughput: with cmd_ready held high, 1 command per cycle is sustained indefinitely.
- Flush:
  - At the edge where flush is high: buf_count = 0, head = tail, inflight = 0. Data returning in the next cycle is discarded.
  - fifo_rd_en is forced low during flush. cmd_valid is low the cycle after.
  - A pop in the flush cycle still counts in cmd_count.
  - Flush does not affect entries still inside the FIFO.
- cmd_count increments on every pop and wraps from 2^CNT_WIDTH−1 to 0.
- idle = (buf_count == 0) && !inflight && fifo_empty.

Test Plan:
- Reset, FIFO empty → fifo_rd_en = 0, cmd_valid = 0, idle = 1, cmd_count = 0 for 10 cycles.
- Single entry 72'h80_0000_0000_DEAD_BEEF, empty falls in cycle N, cmd_ready = 1:
  - Required: fifo_rd_en in N only; cmd_valid in N+2 with cmd_is_read = 1, cmd_addr = 0x00, cmd_data = 0x0000_0000_DEAD_BEEF; cmd_count = 1 afterwards.
- 16 back-to-back entries (addr 0..15, data = addr), cmd_ready = 1:
  - Required: 16 consecutive cmd_valid cycles, in order, no gaps after the first; cmd_count = 16.
- Same 16 entries with cmd_ready low for 5 cycles mid-stream:
  - Required: fifo_rd_en low once buf_count + inflight = 2; head held stable; no loss or duplication; order preserved.
- Flush asserted the cycle after a fifo_rd_en with 2 entries buffered:
  - Required: next cycle cmd_valid = 0; the returning word is discarded; the next FIFO entry is delivered normally afterwards.
- cmd_count preloaded near 0xFFFF via 65 537 pops (or a forced-state check) → wraps to 0x0001. rst asserted while cmd_valid is high → all outputs return to reset values the next cycle.
